l1_read_arbiter: RTL and testbench

Shares one read-only L1 memory port among NUM_PORTS burst requesters, such as the instruction-cache line fill and the data-cache line fill. It grants bursts in round-robin order and holds each grant stable until it is accepted. It records the owner of every accepted burst and steers each returning data beat to that owner. It sits between the caches' read-only master ports and the memory/bus bridge.

---
 rtl/l1_read_arbiter_if.sv | 36 +++
 rtl/l1_read_arbiter.sv | 169 ++++++++++++++++
 tb/tb_l1_read_arbiter.sv | 320 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/l1_read_arbiter_if.sv
// Bundle of the requester-side and memory-side signals of the L1 read arbiter.
//
// Handshake: a requester raises req_request[p] with req_addr[p]/req_rlen[p]
// and holds all three until req_ack[p] pulses; the burst is accepted in that
// cycle. Downstream, mem_request/mem_addr/mem_rlen are presented and the burst
// is accepted in any cycle where mem_request && mem_ack. Data beats carry no
// back-pressure: every cycle with mem_rvalid high is one beat, steered to
// the owner of the oldest accepted burst through req_rvalid/req_rdata.
interface l1_read_arbiter_if #(
  parameter int NUM_PORTS = 2
);
  logic [NUM_PORTS-1:0]       req_request;
  logic [NUM_PORTS-1:0][29:0] req_addr;
  logic [NUM_PORTS-1:0][4:0]  req_rlen;
  logic [NUM_PORTS-1:0]       req_ack;
  logic [NUM_PORTS-1:0]       req_rvalid;
  logic [31:0]                req_rdata;
  logic                       mem_request;
  logic [29:0]                mem_addr;
  logic [4:0]                 mem_rlen;
  logic                       mem_ack;
  logic                       mem_rvalid;
  logic [31:0]                mem_rdata;

  // Arbiter view.
  modport slave (
    input  req_request, req_addr, req_rlen, mem_ack, mem_rvalid, mem_rdata,
    output req_ack, req_rvalid, req_rdata, mem_request, mem_addr, mem_rlen
  );

  // Environment view: requesters plus memory bridge.
  modport master (
    output req_request, req_addr, req_rlen, mem_ack, mem_rvalid, mem_rdata,
    input  req_ack, req_rvalid, req_rdata, mem_request, mem_addr, mem_rlen
  );
endinterface

// File: rtl/l1_read_arbiter.sv
// Round-robin burst arbiter sharing one read-only L1 memory port. The issue
// side picks a requester and holds it stable until memory accepts; the
// return side uses a FIFO of accepted-burst owners to steer data beats.
module l1_read_arbiter #(
  parameter int NUM_PORTS       = 2,
  parameter int MAX_OUTSTANDING = 2,
  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1,
  localparam int AW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1,
  localparam int CW = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  l1_read_arbiter_if.slave     bus,
  output logic                 dbg_state,
  output logic [PW-1:0]        dbg_rr_ptr,
  output logic [CW-1:0]        dbg_count
);

  typedef enum logic {ARB = 1'b0, LOCKED = 1'b1} state_t;

  typedef struct packed {
    logic [PW-1:0] port;
    logic [4:0]    rlen;
  } owner_t;

  state_t        state;
  logic [PW-1:0] sel;
  logic [PW-1:0] rr_ptr;
  logic [PW-1:0] cand;
  logic [PW-1:0] grant;
  logic          mem_req;
  logic          accept;

  owner_t        fifo [MAX_OUTSTANDING];
  owner_t        head;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          fifo_empty;
  logic          owner_full;
  logic          beat;
  logic          last_beat;
  logic [4:0]    beat_cnt;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(MAX_OUTSTANDING - 1)) ? '0 : p + AW'(1);
  endfunction

  assign fifo_empty = (count == '0);
  assign owner_full = (count == CW'(MAX_OUTSTANDING));
  assign head       = fifo[rd_ptr];

  // Candidate: first requesting port at or after rr_ptr, wrapping; port 0 when idle.
  always_comb begin
    int            idx;
    logic          found;
    logic [PW-1:0] pidx;
    idx   = 0;
    found = 1'b0;
    pidx  = '0;
    cand  = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      idx = int'(rr_ptr) + i;
      if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
      pidx = PW'(idx);
      if (!found && bus.req_request[pidx]) begin
        found = 1'b1;
        cand  = pidx;
      end
    end
  end

  // Issue mux: LOCKED pins the presented port so the address cannot switch under memory.
  always_comb begin
    grant   = (state == LOCKED) ? sel : cand;
    mem_req = (state == LOCKED) ? 1'b1 : ((|bus.req_request) && !owner_full);
    accept  = mem_req && bus.mem_ack;
    bus.mem_request = mem_req;
    bus.mem_addr    = bus.req_addr[grant];
    bus.mem_rlen    = bus.req_rlen[grant];
    bus.req_ack     = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (accept && (grant == PW'(p))) bus.req_ack[p] = 1'b1;
    end
  end

  // Return steering: a beat belongs to the head burst; nothing routes while the FIFO is empty.
  always_comb begin
    beat      = bus.mem_rvalid && !fifo_empty;
    last_beat = beat && (beat_cnt == head.rlen);
    bus.req_rdata  = bus.mem_rdata;
    bus.req_rvalid = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (beat && (head.port == PW'(p))) bus.req_rvalid[p] = 1'b1;
    end
  end

  // Issue FSM: latch the presented port when memory stalls, rotate priority on accept.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= ARB;
      sel    <= '0;
      rr_ptr <= '0;
    end else begin
      case (state)
        ARB: begin
          if (mem_req && !bus.mem_ack) begin
            sel   <= cand;
            state <= LOCKED;
          end
        end
        LOCKED: begin
          if (bus.mem_ack) state <= ARB;
        end
        default: state <= ARB;
      endcase
      if (accept) begin
        rr_ptr <= (grant == PW'(NUM_PORTS - 1)) ? '0 : grant + PW'(1);
      end
    end
  end

  // Owner FIFO: push on accept, pop on the last beat of the head burst.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < MAX_OUTSTANDING; i++) fifo[i] <= '0;
    end else begin
      if (accept) begin
        fifo[wr_ptr] <= '{port: grant, rlen: bus.mem_rlen};
        wr_ptr       <= ptr_inc(wr_ptr);
      end
      if (last_beat) rd_ptr <= ptr_inc(rd_ptr);
      case ({accept, last_beat})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Beat counter for the head burst; 5-bit wrap lets rlen 31 mean 32 beats.
  always_ff @(posedge clk) begin
    if (!rst) begin
      beat_cnt <= '0;
    end else if (last_beat) begin
      beat_cnt <= '0;
    end else if (beat) begin
      beat_cnt <= beat_cnt + 5'd1;
    end
  end

  assign dbg_state  = state;
  assign dbg_rr_ptr = rr_ptr;
  assign dbg_count  = count;

  // Protocol errors from the surrounding system; flagged, not recovered.
  a_rvalid_empty: assert property (@(posedge clk) disable iff (!rst)
    bus.mem_rvalid |-> !fifo_empty);
  a_ack_no_req: assert property (@(posedge clk) disable iff (!rst)
    bus.mem_ack |-> mem_req);
  for (genvar gp = 0; gp < NUM_PORTS; gp++) begin : g_req_hold
    a_req_hold: assert property (@(posedge clk) disable iff (!rst)
      (bus.req_request[gp] && !bus.req_ack[gp]) |=> bus.req_request[gp]);
  end

endmodule

// File: tb/tb_l1_read_arbiter.sv
// Directed bench for l1_read_arbiter with two ports and two outstanding bursts.
module tb_l1_read_arbiter;

  logic       clk;
  logic       rst;
  logic       dbg_state;
  logic [0:0] dbg_rr_ptr;
  logic [1:0] dbg_count;
  int         checks;
  int         errors;

  l1_read_arbiter_if #(.NUM_PORTS(2)) bus ();

  l1_read_arbiter #(.NUM_PORTS(2), .MAX_OUTSTANDING(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .dbg_state  (dbg_state),
    .dbg_rr_ptr (dbg_rr_ptr),
    .dbg_count  (dbg_count)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks: inputs change 1ns after the rising edge, checks 1ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input logic [1:0] r);
    bus.req_request = r;
  endtask

  // Directed sequence
  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b0;
    bus.req_request = 2'b00;
    bus.req_addr[0] = 30'h100;
    bus.req_addr[1] = 30'h200;
    bus.req_rlen[0] = 5'd7;
    bus.req_rlen[1] = 5'd0;
    bus.mem_ack     = 1'b0;
    bus.mem_rvalid  = 1'b0;
    bus.mem_rdata   = 32'hDEADBEEF;
    tick();
    tick();
    settle();
    chk("rst_mem_request", {31'd0, bus.mem_request}, 32'd0);
    chk("rst_req_ack", {30'd0, bus.req_ack}, 32'd0);
    chk("rst_req_rvalid", {30'd0, bus.req_rvalid}, 32'd0);
    chk("rst_mem_addr", {2'd0, bus.mem_addr}, 32'h100);
    chk("rst_mem_rlen", {27'd0, bus.mem_rlen}, 32'd7);
    chk("rst_req_rdata", bus.req_rdata, 32'hDEADBEEF);
    chk("rst_state", {31'd0, dbg_state}, 32'd0);
    chk("rst_rr_ptr", {31'd0, dbg_rr_ptr}, 32'd0);
    chk("rst_count", {30'd0, dbg_count}, 32'd0);
    rst = 1'b1;
    tick();

    // Single request: port 0, rlen 7, memory acks in the second cycle.
    set_req(2'b01);
    settle();
    chk("single_c1_mem_request", {31'd0, bus.mem_request}, 32'd1);
    chk("single_c1_req_ack", {30'd0, bus.req_ack}, 32'd0);
    chk("single_c1_mem_addr", {2'd0, bus.mem_addr}, 32'h100);
    tick();
    chk("single_locked", {31'd0, dbg_state}, 32'd1);
    bus.mem_ack = 1'b1;
    settle();
    chk("single_c2_req_ack", {30'd0, bus.req_ack}, 32'd1);
    chk("single_c2_mem_rlen", {27'd0, bus.mem_rlen}, 32'd7);
    tick();
    set_req(2'b00);
    bus.mem_ack = 1'b0;
    settle();
    chk("single_count_after_ack", {30'd0, dbg_count}, 32'd1);
    chk("single_rr_ptr", {31'd0, dbg_rr_ptr}, 32'd1);
    chk("single_state_arb", {31'd0, dbg_state}, 32'd0);
    chk("single_idle_mem_request", {31'd0, bus.mem_request}, 32'd0);
    for (int k = 0; k < 8; k++) begin
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = 32'hA000_0000 + 32'(k);
      settle();
      chk("single_beat_rvalid", {30'd0, bus.req_rvalid}, 32'd1);
      chk("single_beat_rdata", bus.req_rdata, 32'hA000_0000 + 32'(k));
      tick();
    end
    bus.mem_rvalid = 1'b0;
    settle();
    chk("single_fifo_empty", {30'd0, dbg_count}, 32'd0);
    chk("single_no_rvalid", {30'd0, bus.req_rvalid}, 32'd0);
    tick();
    chk("idle_no_rotate", {31'd0, dbg_rr_ptr}, 32'd1);

    // Lock hold: port 1 presented, memory stalls three cycles, port 0 also asking.
    bus.req_rlen[0] = 5'd0;
    bus.req_rlen[1] = 5'd0;
    set_req(2'b11);
    settle();
    chk("lock_l0_mem_addr", {2'd0, bus.mem_addr}, 32'h200);
    chk("lock_l0_mem_request", {31'd0, bus.mem_request}, 32'd1);
    tick();
    for (int k = 0; k < 2; k++) begin
      settle();
      chk("lock_hold_mem_addr", {2'd0, bus.mem_addr}, 32'h200);
      chk("lock_hold_state", {31'd0, dbg_state}, 32'd1);
      chk("lock_hold_req_ack", {30'd0, bus.req_ack}, 32'd0);
      tick();
    end
    bus.mem_ack = 1'b1;
    settle();
    chk("lock_ack_req_ack", {30'd0, bus.req_ack}, 32'd2);
    chk("lock_ack_mem_addr", {2'd0, bus.mem_addr}, 32'h200);
    tick();

    // Contention: acks every cycle, rlen-0 bursts returning one cycle later.
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'hC0;
    settle();
    chk("cont_c0_req_ack", {30'd0, bus.req_ack}, 32'd1);
    chk("cont_c0_rvalid", {30'd0, bus.req_rvalid}, 32'd2);
    chk("cont_c0_mem_addr", {2'd0, bus.mem_addr}, 32'h100);
    tick();
    bus.mem_rdata = 32'hC1;
    settle();
    chk("cont_c1_req_ack", {30'd0, bus.req_ack}, 32'd2);
    chk("cont_c1_rvalid", {30'd0, bus.req_rvalid}, 32'd1);
    chk("cont_c1_mem_addr", {2'd0, bus.mem_addr}, 32'h200);
    tick();
    bus.mem_rdata = 32'hC2;
    settle();
    chk("cont_c2_req_ack", {30'd0, bus.req_ack}, 32'd1);
    chk("cont_c2_rvalid", {30'd0, bus.req_rvalid}, 32'd2);
    tick();
    set_req(2'b10);
    bus.mem_rdata = 32'hC3;
    settle();
    chk("cont_c3_req_ack", {30'd0, bus.req_ack}, 32'd2);
    chk("cont_c3_rvalid", {30'd0, bus.req_rvalid}, 32'd1);
    chk("cont_c3_count", {30'd0, dbg_count}, 32'd1);
    tick();
    set_req(2'b00);
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 32'hC4;
    settle();
    chk("cont_c4_rvalid", {30'd0, bus.req_rvalid}, 32'd2);
    chk("cont_c4_mem_request", {31'd0, bus.mem_request}, 32'd0);
    tick();
    bus.mem_rvalid = 1'b0;
    settle();
    chk("cont_drained", {30'd0, dbg_count}, 32'd0);
    chk("cont_rr_ptr", {31'd0, dbg_rr_ptr}, 32'd0);

    // Full FIFO: two accepts with no data block the third request.
    bus.req_rlen[0] = 5'd1;
    set_req(2'b01);
    bus.mem_ack = 1'b1;
    settle();
    chk("full_f0_req_ack", {30'd0, bus.req_ack}, 32'd1);
    tick();
    settle();
    chk("full_f1_req_ack", {30'd0, bus.req_ack}, 32'd1);
    tick();
    bus.mem_ack    = 1'b0;
    bus.mem_rvalid = 1'b1;
    settle();
    chk("full_f2_count", {30'd0, dbg_count}, 32'd2);
    chk("full_f2_mem_request", {31'd0, bus.mem_request}, 32'd0);
    chk("full_f2_rvalid", {30'd0, bus.req_rvalid}, 32'd1);
    tick();
    settle();
    chk("full_f3_mem_request", {31'd0, bus.mem_request}, 32'd0);
    chk("full_f3_rvalid", {30'd0, bus.req_rvalid}, 32'd1);
    tick();
    bus.mem_rvalid = 1'b0;
    settle();
    chk("full_f4_count", {30'd0, dbg_count}, 32'd1);
    chk("full_f4_mem_request", {31'd0, bus.mem_request}, 32'd1);
    bus.mem_ack = 1'b1;
    settle();
    chk("full_f4_req_ack", {30'd0, bus.req_ack}, 32'd1);
    tick();
    set_req(2'b00);
    bus.mem_ack = 1'b0;
    for (int k = 0; k < 4; k++) begin
      bus.mem_rvalid = 1'b1;
      settle();
      chk("full_drain_rvalid", {30'd0, bus.req_rvalid}, 32'd1);
      tick();
    end
    bus.mem_rvalid = 1'b0;
    settle();
    chk("full_drained", {30'd0, dbg_count}, 32'd0);

    // Back-to-back ownership: port 0 rlen 3 then port 1 rlen 0.
    bus.req_addr[0] = 30'h140;
    bus.req_addr[1] = 30'h240;
    bus.req_rlen[0] = 5'd3;
    set_req(2'b01);
    bus.mem_ack = 1'b1;
    settle();
    chk("b2b_b0_req_ack", {30'd0, bus.req_ack}, 32'd1);
    chk("b2b_b0_mem_addr", {2'd0, bus.mem_addr}, 32'h140);
    tick();
    set_req(2'b10);
    settle();
    chk("b2b_b1_req_ack", {30'd0, bus.req_ack}, 32'd2);
    tick();
    set_req(2'b00);
    bus.mem_ack = 1'b0;
    settle();
    chk("b2b_count", {30'd0, dbg_count}, 32'd2);
    for (int k = 0; k < 4; k++) begin
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = 32'hB000 + 32'(k);
      settle();
      chk("b2b_port0_beat", {30'd0, bus.req_rvalid}, 32'd1);
      tick();
    end
    bus.req_rlen[0] = 5'd0;
    set_req(2'b01);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'hB004;
    settle();
    chk("b2b_beat5_rvalid", {30'd0, bus.req_rvalid}, 32'd2);
    chk("b2b_beat5_rdata", bus.req_rdata, 32'hB004);
    chk("b2b_push_req_ack", {30'd0, bus.req_ack}, 32'd1);
    tick();
    set_req(2'b00);
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 32'hB005;
    settle();
    chk("b2b_pushpop_count", {30'd0, dbg_count}, 32'd1);
    chk("b2b_new_head_rvalid", {30'd0, bus.req_rvalid}, 32'd1);
    tick();
    bus.mem_rvalid = 1'b0;
    settle();
    chk("b2b_drained", {30'd0, dbg_count}, 32'd0);

    // Reset mid-burst: rlen 7, two beats in, then reset.
    bus.req_addr[0] = 30'h100;
    bus.req_rlen[0] = 5'd7;
    set_req(2'b01);
    bus.mem_ack = 1'b1;
    settle();
    chk("rmid_req_ack", {30'd0, bus.req_ack}, 32'd1);
    tick();
    set_req(2'b00);
    bus.mem_ack = 1'b0;
    for (int k = 0; k < 2; k++) begin
      bus.mem_rvalid = 1'b1;
      settle();
      chk("rmid_beat_rvalid", {30'd0, bus.req_rvalid}, 32'd1);
      tick();
    end
    bus.mem_rvalid = 1'b0;
    settle();
    chk("rmid_pre_count", {30'd0, dbg_count}, 32'd1);
    chk("rmid_pre_rr_ptr", {31'd0, dbg_rr_ptr}, 32'd1);
    bus.req_addr[0] = 30'h0;
    bus.req_addr[1] = 30'h0;
    bus.req_rlen[0] = 5'd0;
    bus.req_rlen[1] = 5'd0;
    bus.mem_rdata   = 32'h0;
    rst = 1'b0;
    tick();
    settle();
    chk("rmid_mem_request", {31'd0, bus.mem_request}, 32'd0);
    chk("rmid_req_ack", {30'd0, bus.req_ack}, 32'd0);
    chk("rmid_req_rvalid", {30'd0, bus.req_rvalid}, 32'd0);
    chk("rmid_mem_addr", {2'd0, bus.mem_addr}, 32'd0);
    chk("rmid_mem_rlen", {27'd0, bus.mem_rlen}, 32'd0);
    chk("rmid_req_rdata", bus.req_rdata, 32'd0);
    chk("rmid_count", {30'd0, dbg_count}, 32'd0);
    chk("rmid_rr_ptr", {31'd0, dbg_rr_ptr}, 32'd0);
    chk("rmid_state", {31'd0, dbg_state}, 32'd0);
    rst = 1'b1;
    tick();

    // After reset a fresh rlen-0 burst must complete in one beat.
    bus.req_addr[0] = 30'h300;
    set_req(2'b01);
    bus.mem_ack = 1'b1;
    settle();
    chk("post_req_ack", {30'd0, bus.req_ack}, 32'd1);
    chk("post_mem_addr", {2'd0, bus.mem_addr}, 32'h300);
    tick();
    set_req(2'b00);
    bus.mem_ack    = 1'b0;
    bus.mem_rvalid = 1'b1;
    settle();
    chk("post_beat_rvalid", {30'd0, bus.req_rvalid}, 32'd1);
    tick();
    bus.mem_rvalid = 1'b0;
    settle();
    chk("post_count", {30'd0, dbg_count}, 32'd0);

    // Final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
